// File: rtl/hazard_forward_unit_if.sv
// ID-stage decode/control bundle between the decoder/datapath (master) and the hazard unit (slave).
// The master drives the ID-stage instruction fields; the slave returns enables, flushes and forward selects.
interface hazard_forward_unit_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned OPT_W = 2
);
    logic [REG_W-1:0] rs1_ID;
    logic [REG_W-1:0] rs2_ID;
    logic [REG_W-1:0] rd_ID;
    logic             rs1use_ID;
    logic             rs2use_ID;
    logic [OPT_W-1:0] hazard_optype_ID;
    logic             Branch_ID;

    logic             PC_EN_IF;
    logic             reg_FD_EN;
    logic             reg_FD_flush;
    logic             reg_DE_flush;
    logic [1:0]       forward_ctrl_A;
    logic [1:0]       forward_ctrl_B;
    logic             forward_ctrl_ls;

    modport master (
        output rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID,
        input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID,
        output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall and forwarding-select generation, tracking EX/MEM destination and op-type in a
// private shadow pipeline. Outputs are combinational from shadow state and the ID-stage inputs.
module hazard_forward_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned OPT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  hz
);
    localparam logic [OPT_W-1:0] OPT_NONE  = OPT_W'(0);
    localparam logic [OPT_W-1:0] OPT_ALU   = OPT_W'(1);
    localparam logic [OPT_W-1:0] OPT_LOAD  = OPT_W'(2);
    localparam logic [OPT_W-1:0] OPT_STORE = OPT_W'(3);

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    logic [OPT_W-1:0] opt_ex_q, opt_ex_d, opt_mem_q, opt_mem_d;
    logic [REG_W-1:0] rd_ex_q, rd_ex_d, rd_mem_q, rd_mem_d, rd2_ex_q, rd2_ex_d;
    logic             st_fwd_ex_q, st_fwd_ex_d;

    logic writes_ex, writes_mem;
    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
    logic ls_exempt, stall;

    // Register match terms; x0 is excluded through the writes_* qualifiers.
    always_comb begin
        writes_ex  = ((opt_ex_q == OPT_ALU) || (opt_ex_q == OPT_LOAD)) && (rd_ex_q != '0);
        writes_mem = ((opt_mem_q == OPT_ALU) || (opt_mem_q == OPT_LOAD)) && (rd_mem_q != '0);
        hit_ex1    = hz.rs1use_ID && writes_ex  && (rd_ex_q  == hz.rs1_ID);
        hit_ex2    = hz.rs2use_ID && writes_ex  && (rd_ex_q  == hz.rs2_ID);
        hit_mem1   = hz.rs1use_ID && writes_mem && (rd_mem_q == hz.rs1_ID);
        hit_mem2   = hz.rs2use_ID && writes_mem && (rd_mem_q == hz.rs2_ID);
        ls_exempt  = (hz.hazard_optype_ID == OPT_STORE) && (opt_ex_q == OPT_LOAD)
                     && hit_ex2 && !hit_ex1;
        stall      = (opt_ex_q == OPT_LOAD) && (hit_ex1 || (hit_ex2 && !ls_exempt));
    end

    // Pipeline control and operand selects; EX forwarding has priority over MEM.
    always_comb begin
        hz.PC_EN_IF     = !stall;
        hz.reg_FD_EN    = !stall;
        hz.reg_DE_flush = stall;
        hz.reg_FD_flush = hz.Branch_ID && !stall;

        hz.forward_ctrl_A = FWD_RF;
        if (hit_ex1 && (opt_ex_q == OPT_ALU))
            hz.forward_ctrl_A = FWD_EX_ALU;
        else if (hit_mem1)
            hz.forward_ctrl_A = (opt_mem_q == OPT_LOAD) ? FWD_MEM_LD : FWD_MEM_ALU;

        hz.forward_ctrl_B = FWD_RF;
        if (ls_exempt)
            hz.forward_ctrl_B = FWD_RF;
        else if (hit_ex2 && (opt_ex_q == OPT_ALU))
            hz.forward_ctrl_B = FWD_EX_ALU;
        else if (hit_mem2)
            hz.forward_ctrl_B = (opt_mem_q == OPT_LOAD) ? FWD_MEM_LD : FWD_MEM_ALU;

        hz.forward_ctrl_ls = st_fwd_ex_q && (opt_mem_q == OPT_LOAD) && (rd_mem_q == rd2_ex_q);
    end

    // Shadow pipeline advance; a stall turns the EX slot into a bubble.
    always_comb begin
        opt_mem_d   = opt_ex_q;
        rd_mem_d    = rd_ex_q;
        opt_ex_d    = hz.hazard_optype_ID;
        rd_ex_d     = hz.rd_ID;
        rd2_ex_d    = hz.rs2_ID;
        st_fwd_ex_d = ls_exempt;
        if (stall) begin
            opt_ex_d    = OPT_NONE;
            rd_ex_d     = '0;
            rd2_ex_d    = rd2_ex_q;
            st_fwd_ex_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opt_ex_q    <= OPT_NONE;
            rd_ex_q     <= '0;
            rd2_ex_q    <= '0;
            st_fwd_ex_q <= 1'b0;
            opt_mem_q   <= OPT_NONE;
            rd_mem_q    <= '0;
        end else begin
            opt_ex_q    <= opt_ex_d;
            rd_ex_q     <= rd_ex_d;
            rd2_ex_q    <= rd2_ex_d;
            st_fwd_ex_q <= st_fwd_ex_d;
            opt_mem_q   <= opt_mem_d;
            rd_mem_q    <= rd_mem_d;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit: stimulus pushes hand-computed expectations into a
// scoreboard queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_forward_unit;
    logic clk;
    logic rst;

    hazard_forward_unit_if #(.REG_W(5), .OPT_W(2)) bus ();

    hazard_forward_unit #(.REG_W(5), .OPT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       fd_en;
        logic       fd_flush;
        logic       de_flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fls;
    } resp_t;

    typedef struct {
        resp_t exp;
        string name;
    } sb_t;

    sb_t sb_q[$];
    logic chk_active;
    int   n_checks;
    int   n_fail;

    function automatic resp_t run_exp(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic fls, input logic fdf);
        resp_t r;
        r = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: fdf, de_flush: 1'b0, fa: fa, fb: fb, fls: fls};
        return r;
    endfunction

    function automatic resp_t stall_exp(input logic [1:0] fa, input logic [1:0] fb);
        resp_t r;
        r = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_flush: 1'b1, fa: fa, fb: fb, fls: 1'b0};
        return r;
    endfunction

    // One ID-stage cycle: inputs change just after the rising edge, checked on the falling edge.
    task automatic apply(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [1:0] opt, input logic br, input logic chk,
                         input resp_t e, input string nm);
        sb_t item;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.rs1_ID           = rs1;
        bus.rs2_ID           = rs2;
        bus.rd_ID            = rd;
        bus.rs1use_ID        = u1;
        bus.rs2use_ID        = u2;
        bus.hazard_optype_ID = opt;
        bus.Branch_ID        = br;
        if (chk) begin
            item.exp  = e;
            item.name = nm;
            sb_q.push_back(item);
        end
        chk_active = chk;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (chk_active) begin
            resp_t act;
            sb_t   item;
            act = '{pc_en: bus.PC_EN_IF, fd_en: bus.reg_FD_EN, fd_flush: bus.reg_FD_flush,
                    de_flush: bus.reg_DE_flush, fa: bus.forward_ctrl_A,
                    fb: bus.forward_ctrl_B, fls: bus.forward_ctrl_ls};
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got %b with no expectation queued", act);
            end else begin
                item = sb_q.pop_front();
                if (act !== item.exp) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%b fd=%b fdf=%b def=%b A=%0d B=%0d ls=%b, want pc=%b fd=%b fdf=%b def=%b A=%0d B=%0d ls=%b",
                             item.name, act.pc_en, act.fd_en, act.fd_flush, act.de_flush,
                             act.fa, act.fb, act.fls, item.exp.pc_en, item.exp.fd_en,
                             item.exp.fd_flush, item.exp.de_flush, item.exp.fa, item.exp.fb,
                             item.exp.fls);
                end
            end
        end
    end

    initial begin
        resp_t nil;
        nil        = '0;
        n_checks   = 0;
        n_fail     = 0;
        chk_active = 1'b0;
        rst        = 1'b1;
        bus.rs1_ID = '0; bus.rs2_ID = '0; bus.rd_ID = '0;
        bus.rs1use_ID = 1'b0; bus.rs2use_ID = 1'b0;
        bus.hazard_optype_ID = 2'd0; bus.Branch_ID = 1'b0;

        //      rst rs1 rs2 rd  u1 u2 opt br chk
        apply(1, 0,  0,  0,  0, 0, 0, 0, 0, nil, "rst0");
        apply(1, 0,  0,  0,  0, 0, 0, 0, 0, nil, "rst1");
        apply(0, 0,  0,  0,  0, 0, 0, 0, 1, run_exp(0, 0, 0, 0), "reset_idle");
        // ALU back-to-back
        apply(0, 1,  2,  5,  0, 0, 1, 0, 1, run_exp(0, 0, 0, 0), "alu_prod");
        apply(0, 5,  0,  9,  1, 0, 1, 0, 1, run_exp(1, 0, 0, 0), "alu_ex_fwd");
        apply(0, 5,  0,  0,  1, 0, 0, 0, 1, run_exp(2, 0, 0, 0), "alu_mem_fwd");
        // Load-use on rs2
        apply(0, 1,  0,  6,  1, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x6");
        apply(0, 3,  6, 10,  1, 1, 1, 0, 1, stall_exp(0, 0),     "lu_stall");
        apply(0, 3,  6, 10,  1, 1, 1, 0, 1, run_exp(0, 3, 0, 0), "lu_mem_ld");
        // Store-data exemption
        apply(0, 0,  0,  7,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x7");
        apply(0, 2,  7,  0,  1, 1, 3, 0, 1, run_exp(0, 0, 0, 0), "sw_exempt");
        apply(0, 0,  0,  0,  0, 0, 0, 0, 1, run_exp(0, 0, 1, 0), "st_fwd_ls");
        // x0 never matches
        apply(0, 0,  0,  0,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x0");
        apply(0, 0,  0,  8,  1, 1, 1, 0, 1, run_exp(0, 0, 0, 0), "use_x0");
        // EX over MEM priority
        apply(0, 0,  0,  8,  0, 0, 1, 0, 1, run_exp(0, 0, 0, 0), "add_x8_again");
        apply(0, 8,  8,  0,  1, 1, 0, 0, 1, run_exp(1, 1, 0, 0), "ex_priority");
        // Branch vs stall
        apply(0, 0,  0,  0,  0, 0, 0, 1, 1, run_exp(0, 0, 0, 1), "branch_flush");
        apply(0, 0,  0, 11,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x11");
        apply(0, 11, 0,  0,  1, 0, 0, 1, 1, stall_exp(0, 0),     "branch_stall");
        apply(0, 11, 0,  0,  1, 0, 0, 1, 1, run_exp(3, 0, 0, 1), "branch_retry");
        // Reset with a load pending in EX
        apply(0, 0,  0, 12,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x12");
        apply(1, 12, 0,  0,  1, 0, 0, 0, 0, nil, "rst_mid");
        apply(0, 12, 0,  0,  1, 0, 0, 0, 1, run_exp(0, 0, 0, 0), "post_reset");
        // Back-to-back loads into one consumer stall once
        apply(0, 0,  0, 13,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x13");
        apply(0, 0,  0, 14,  0, 0, 2, 0, 1, run_exp(0, 0, 0, 0), "lw_x14");
        apply(0, 13, 14, 15, 1, 1, 1, 0, 1, stall_exp(3, 0),     "b2b_stall");
        apply(0, 13, 14, 15, 1, 1, 1, 0, 1, run_exp(0, 3, 0, 0), "b2b_resume");
        apply(0, 0,  0,  0,  0, 0, 0, 0, 1, run_exp(0, 0, 0, 0), "tail_idle");
        apply(0, 0,  0,  0,  0, 0, 0, 0, 0, nil, "drain");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Consumer end of the decode-stage control interface. It takes the per-instruction rs1use, rs2use and hazard_optype from the ID-stage decoder, together with register indices.
- It keeps its own shadow pipeline of destination and op-type for the EX and MEM stages.
- Outputs: pipeline enables and flushes, load-use stalls, and forwarding selects for the ID-stage branch comparator/operand path and for store data in EX.

Parameters:
- REG_W, 5, register index width.
- OPT_W, 2, hazard_optype width. Encoding: 0 = none, 1 = ALU, 2 = LOAD, 3 = STORE.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- rs1_ID  in  REG_W  rs1 field of the ID instruction
- rs2_ID  in  REG_W  rs2 field of the ID instruction
- rd_ID  in  REG_W  rd field of the ID instruction
- rs1use_ID  in  1  decoder rs1use
- rs2use_ID  in  1  decoder rs2use
- hazard_optype_ID  in  OPT_W  decoder hazard_optype
- Branch_ID  in  1  decoder Branch (taken branch / jump this cycle)
- PC_EN_IF  out  1  PC register enable
- reg_FD_EN  out  1  IF/ID register enable
- reg_FD_flush  out  1  IF/ID flush
- reg_DE_flush  out  1  ID/EX flush (insert bubble)
- forward_ctrl_A  out  2  rs1 operand select in ID: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data
- forward_ctrl_B  out  2  rs2 operand select in ID, same encoding
- forward_ctrl_ls  out  1  store data in EX taken from MEM load data

Behaviour:
- State registers:
  - opt_EX, rd_EX, st_fwd_EX (store rs2 pending from load), rd2_EX
  - opt_MEM, rd_MEM
- Each clk:
  - if rst: all opt_* = 0, rd_* = 0, st_fwd_EX = 0.
  - else: opt_MEM <= opt_EX; rd_MEM <= rd_EX.
  - If reg_DE_flush: opt_EX <= 0, rd_EX <= 0, st_fwd_EX <= 0.
  - Otherwise: opt_EX <= hazard_optype_ID; rd_EX <= rd_ID; rd2_EX <= rs2_ID; st_fwd_EX <= ls_exempt (defined below).
- A stage "writes" when its opt is 1 or 2 and its rd != 0. Register x0 never matches.
- Match terms:
  - hitEX1 = rs1use_ID & writesEX & rd_EX == rs1_ID (hitEX2 likewise for rs2, hitMEM1/2 likewise for MEM).
- Load-use:
  - ls_exempt = hazard_optype_ID == 3 & opt_EX == 2 & hitEX2 & !hitEX1. This is the store-data-only dependency and does not stall.
  - stall = opt_EX == 2 & (hitEX1 | (hitEX2 & !ls_exempt)).
- Outputs are combinational from state and inputs:
  - PC_EN_IF = !stall; reg_FD_EN = !stall; reg_DE_flush = stall.
  - reg_FD_flush = Branch_ID & !stall. Stall wins over branch; the branch is re-evaluated next cycle with correct operands.
  - forward_ctrl_A:
    - hitEX1 & opt_EX == 1 -> 1
    - else hitMEM1 -> (opt_MEM == 2 ? 3 : 2)
    - else 0.
    - EX has priority over MEM. When stall is active the value is don't-care but must still follow this rule.
  - forward_ctrl_B: same rule on rs2. Under ls_exempt it is 0; the data is provided later via forward_ctrl_ls.
  - forward_ctrl_ls = st_fwd_EX & opt_MEM == 2 & rd_MEM == rd2_EX.
- Latency:
  - Load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM and the select is 3.
  - Back-to-back loads feeding the same consumer stall only once.
- Reset mid-operation: the next cycle has no stall, all forwards 0, PC_EN_IF = 1, reg_FD_EN = 1.
- Reset values of outputs, with inputs idle: PC_EN_IF = 1, reg_FD_EN = 1, reg_FD_flush = 0, reg_DE_flush = 0, forward_ctrl_A = 0, forward_ctrl_B = 0, forward_ctrl_ls = 0.

Test Plan:
- ALU back-to-back: add x5 in ID, then ID rs1 = 5, rs1use = 1 -> forward_ctrl_A = 1, no stall. The cycle after, a third consumer of x5 gets forward_ctrl_A = 2.
- Load-use: lw x6 (opt 2) then add using rs2 = 6 -> one cycle with PC_EN_IF = 0, reg_FD_EN = 0, reg_DE_flush = 1. Next cycle forward_ctrl_B = 3, no stall.
- Store exemption: lw x7 then sw with rs2 = 7, rs1 = 2 -> no stall, forward_ctrl_B = 0. Next cycle forward_ctrl_ls = 1.
- x0 and priority: lw x0 then a use of x0 -> no stall, forward 0. Both EX and MEM writing x8 (ALU) -> forward_ctrl_A = 1.
- Branch vs stall: Branch_ID = 1 with no hazard -> reg_FD_flush = 1. Branch_ID = 1 during load-use -> reg_FD_flush = 0, stall = 1.
- Reset: assert rst during a pending load in EX -> next cycle all forwards 0, PC_EN_IF = 1, reg_DE_flush = 0.
